// File: rtl/perceptron_activation.sv
// Perceptron output stage: tracks start pulses through the weighted-sum latency, adds bias,
// rescales Q30->Q15 with saturation, applies step/ReLU and queues results. Macro: PERCEPTRON_ROUND_EN.
module perceptron_activation #(
  parameter int LATENCY    = 10,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [47:0]      sum,
  input  logic [47:0]      bias,
  input  logic             mode,
  output logic             start_ok,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             dropped
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + LATENCY + 3) + 1;

  localparam logic signed [49:0] SAT_MAX = (50'sd1 <<< (OUT_W - 1)) - 50'sd1;
  localparam logic signed [49:0] SAT_MIN = -(50'sd1 <<< (OUT_W - 1));
  localparam logic [OUT_W-1:0]   POS_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]   NEG_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Latency tracker
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] tracker_reg;
  logic [LATENCY-1:0] tracker_next;
  logic               tap;

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tracker
      if (gi == 0) begin : g_head
        assign tracker_next[gi] = start;
      end else begin : g_body
        assign tracker_next[gi] = tracker_reg[gi-1];
      end
    end
  endgenerate

  assign tap = tracker_reg[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Stage 1: bias add at 49 bits so it cannot wrap
  // ---------------------------------------------------------------------------
  logic signed [48:0] acc_reg;
  logic               mode_reg;
  logic               v1_reg;

  // ---------------------------------------------------------------------------
  // Stage 2: rescale, saturate, activate
  // ---------------------------------------------------------------------------
  logic signed [49:0] acc_ext;
  logic signed [49:0] shifted;
  logic               sat_hi;
  logic               sat_lo;
  logic [OUT_W-1:0]   sat_val;
  logic [OUT_W-1:0]   act_val;
  logic [OUT_W-1:0]   res_reg;
  logic               v2_reg;

  always_comb begin
`ifdef PERCEPTRON_ROUND_EN
    acc_ext = {acc_reg[48], acc_reg} + (50'sd1 <<< (FRAC_SHIFT - 1));
`else
    acc_ext = {acc_reg[48], acc_reg};
`endif
    shifted = acc_ext >>> FRAC_SHIFT;
    sat_hi  = (shifted > SAT_MAX);
    sat_lo  = (shifted < SAT_MIN);
    if (sat_hi) begin
      sat_val = POS_MAX;
    end else if (sat_lo) begin
      sat_val = NEG_MIN;
    end else begin
      sat_val = shifted[OUT_W-1:0];
    end
    // Step decides on the unscaled sign, so a zero accumulator fires.
    if (mode_reg) begin
      act_val = sat_val[OUT_W-1] ? '0 : sat_val;
    end else begin
      act_val = acc_reg[48] ? '0 : POS_MAX;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;
  logic             full;
  logic             accept;
  logic             drop;

  assign out_valid = (count_reg != '0);
  assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
  assign push      = v2_reg;
  assign pop       = out_valid && out_ready;
  // A push on a full FIFO only lands if the head leaves on the same edge.
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_comb begin
    wr_ptr_next = accept ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    count_next  = count_reg;
    case ({accept, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  assign out_data = out_valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg] <= res_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Credit: counts everything that will eventually occupy a FIFO slot, using
  // next-state values so a start on the edge that fills the budget is seen.
  // ---------------------------------------------------------------------------
  logic [OCC_W-1:0] occ_next;
  logic             start_ok_reg;

  always_comb begin
    occ_next = OCC_W'(count_next) + OCC_W'(tap) + OCC_W'(v1_reg);
    for (int i = 0; i < LATENCY; i++) begin
      occ_next = occ_next + OCC_W'(tracker_next[i]);
    end
  end

  assign start_ok = start_ok_reg;

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  logic overflow_reg;
  logic dropped_reg;

  assign overflow = overflow_reg;
  assign dropped  = dropped_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tracker_reg  <= '0;
      v1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      dropped_reg  <= 1'b0;
      start_ok_reg <= 1'b1;
    end else begin
      tracker_reg  <= tracker_next;
      v1_reg       <= tap;
      v2_reg       <= v1_reg;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      start_ok_reg <= (occ_next < OCC_W'(FIFO_DEPTH));
      if (v1_reg && mode_reg && (sat_hi || sat_lo)) begin
        overflow_reg <= 1'b1;
      end
      if (drop) begin
        dropped_reg <= 1'b1;
      end
    end
  end

  // Datapath registers need no reset; their valids gate every use.
  always_ff @(posedge clk) begin
    if (tap) begin
      acc_reg  <= {sum[47], sum} + {bias[47], bias};
      mode_reg <= mode;
    end
    if (v1_reg) begin
      res_reg <= act_val;
    end
  end

endmodule

// File: tb/tb_perceptron_activation.sv
// Directed bench for perceptron_activation; models the weighted-sum chain as a delay
// line so each start's sum/mode reaches the DUT exactly at its tap edge.
module tb_perceptron_activation;

  localparam int LATENCY = 10;
  localparam int OUT_W   = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [47:0]      sum;
  logic [47:0]      bias;
  logic             mode;
  logic             start_ok;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic             dropped;

  int n_cmp;
  int n_bad;

  logic [47:0] next_sum;
  logic        next_mode;
  logic [47:0] sum_pipe  [LATENCY];
  logic        mode_pipe [LATENCY];

  perceptron_activation #(
    .LATENCY(LATENCY), .OUT_W(OUT_W), .FRAC_SHIFT(15), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sum(sum), .bias(bias), .mode(mode),
    .start_ok(start_ok), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    sum_pipe[0]  <= next_sum;
    mode_pipe[0] <= next_mode;
    for (int i = 1; i < LATENCY; i++) begin
      sum_pipe[i]  <= sum_pipe[i-1];
      mode_pipe[i] <= mode_pipe[i-1];
    end
  end

  assign sum  = sum_pipe[LATENCY-1];
  assign mode = mode_pipe[LATENCY-1];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [47:0] s, input logic m);
    next_sum  = s;
    next_mode = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output logic got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      if (out_valid) got = 1'b1;
      else tick();
    end
  endtask

  task automatic pop_one;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h want 0000", out_data); end
    n_cmp++; if (start_ok !== 1'b1) begin n_bad++; $display("FAIL reset_start_ok: got %b want 1", start_ok); end
    n_cmp++; if (overflow !== 1'b0 || dropped !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got ovf=%b drop=%b want 0/0", overflow, dropped); end
    $display("reset: valid=%b data=%h start_ok=%b", out_valid, out_data, start_ok);
  endtask

  task automatic test_relu;
    do_start(48'h0000_2000_0000, 1'b1);
    for (int i = 0; i < 11; i++) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL relu_early: valid=%b want 0 one cycle before result", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL relu_latency: valid=%b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h4000) begin n_bad++; $display("FAIL relu_data: got %h want 4000", out_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL relu_overflow: got %b want 0", overflow); end
    $display("relu: data=%h valid=%b ovf=%b", out_data, out_valid, overflow);
    pop_one();
  endtask

  task automatic test_step_neg;
    logic [47:0] sv   [3] = '{48'hFFFF_E000_0000, 48'hFFFF_E000_0000, 48'h0};
    logic        mv   [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] ev   [3] = '{16'h0000, 16'h0000, 16'h7FFF};
    logic        got;
    for (int k = 0; k < 3; k++) begin
      do_start(sv[k], mv[k]);
      wait_valid(30, got);
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL step_neg_%0d_timeout: valid=%b want 1", k, out_valid); end
      n_cmp++; if (out_data !== ev[k]) begin n_bad++; $display("FAIL step_neg_%0d_data: got %h want %h", k, out_data, ev[k]); end
      $display("step_neg %0d: sum=%h mode=%b data=%h", k, sv[k], mv[k], out_data);
      pop_one();
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL step_neg_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_saturation;
    logic got;
    do_start(48'h0001_0000_0000, 1'b1);
    wait_valid(30, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL sat_timeout: valid=%b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h7FFF) begin n_bad++; $display("FAIL sat_data: got %h want 7fff", out_data); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL sat_overflow: got %b want 1", overflow); end
    $display("saturation: data=%h ovf=%b", out_data, overflow);
    pop_one();
    do_start(48'h0000_0000_8000, 1'b1);
    wait_valid(30, got);
    n_cmp++; if (got !== 1'b1 || out_data !== 16'h0001) begin n_bad++; $display("FAIL sat_follow: valid=%b data=%h want 1/0001", got, out_data); end
    pop_one();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL sat_sticky: got %b want 1", overflow); end
    $display("saturation sticky: ovf=%b", overflow);
  endtask

  task automatic test_bias_round;
    logic        got;
    logic [15:0] exp_half;
`ifdef PERCEPTRON_ROUND_EN
    exp_half = 16'h0001;
`else
    exp_half = 16'h0000;
`endif
    bias = 48'h0000_0000_8000;
    do_start(48'h0, 1'b1);
    wait_valid(30, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL bias_timeout: valid=%b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h0001) begin n_bad++; $display("FAIL bias_data: got %h want 0001", out_data); end
    $display("bias: data=%h", out_data);
    pop_one();
    bias = 48'h0;
    do_start(48'h0000_0000_4000, 1'b1);
    wait_valid(30, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL half_timeout: valid=%b want 1", out_valid); end
    n_cmp++; if (out_data !== exp_half) begin n_bad++; $display("FAIL half_data: got %h want %h", out_data, exp_half); end
    $display("half-lsb: data=%h", out_data);
    pop_one();
  endtask

  task automatic test_back_to_back;
    logic got;
    out_ready = 1'b1;
    for (int k = 7; k <= 9; k++) do_start(48'(k) << 15, 1'b1);
    wait_valid(30, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_timeout: valid=%b want 1", out_valid); end
    for (int k = 7; k <= 9; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'(k)) begin n_bad++; $display("FAIL b2b_%0d: valid=%b data=%h want 1/%h", k, out_valid, out_data, 16'(k)); end
      $display("b2b: data=%h", out_data);
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: valid=%b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    n_cmp++; if (dropped !== 1'b0) begin n_bad++; $display("FAIL bp_drop_pre: got %b want 0", dropped); end
    for (int k = 1; k <= 6; k++) begin
      do_start(48'(k) << 15, 1'b1);
      if (k == 3) begin
        n_cmp++; if (start_ok !== 1'b1) begin n_bad++; $display("FAIL bp_ok_after3: got %b want 1", start_ok); end
      end
      if (k == 4) begin
        n_cmp++; if (start_ok !== 1'b0) begin n_bad++; $display("FAIL bp_ok_after4: got %b want 0", start_ok); end
      end
    end
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (dropped !== 1'b1) begin n_bad++; $display("FAIL bp_dropped: got %b want 1", dropped); end
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'(k)) begin n_bad++; $display("FAIL bp_read_%0d: valid=%b data=%h want 1/%h", k, out_valid, out_data, 16'(k)); end
      $display("backpressure read: data=%h", out_data);
      pop_one();
    end
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin n_bad++; $display("FAIL bp_empty: valid=%b data=%h want 0/0000", out_valid, out_data); end
    n_cmp++; if (start_ok !== 1'b1) begin n_bad++; $display("FAIL bp_ok_end: got %b want 1", start_ok); end
  endtask

  task automatic test_reset_midstream;
    logic seen;
    for (int k = 1; k <= 3; k++) do_start(48'(k) << 15, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: saw valid=1 want none"); end
    n_cmp++; if (start_ok !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ok: got %b want 1", start_ok); end
    n_cmp++; if (overflow !== 1'b0 || dropped !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: ovf=%b drop=%b want 0/0", overflow, dropped); end
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_data: got %h want 0000", out_data); end
    $display("reset midstream: valid_seen=%b start_ok=%b ovf=%b drop=%b", seen, start_ok, overflow, dropped);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    bias      = 48'h0;
    out_ready = 1'b0;
    next_sum  = 48'h0;
    next_mode = 1'b0;
    test_reset();
    test_relu();
    test_step_neg();
    test_saturation();
    test_bias_round();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/perceptron_activation.md
Name: perceptron_activation

Overview:
- Downstream stage of the DSP48 weighted-sum chain.
- Tracks each start pulse through the chain's fixed pipeline latency and captures the 48-bit sum at exactly the right cycle.
- Adds a bias, rescales Q30 to Q15, saturates, and applies a step or ReLU activation.
- Buffers results in a small FIFO with a valid/ready handshake toward the next layer or host. Issues a start_ok credit so the controller never overruns the FIFO.

Parameters:
- LATENCY, 10: cycles from start pulse (x/w presented to the weighted sum) to the matching sum being valid; >=1.
- OUT_W, 16: signed output width.
- FRAC_SHIFT, 15: arithmetic right shift applied to (sum+bias); Q15*Q15 products to Q15; >=1.
- FIFO_DEPTH, 4: output FIFO entries; power of 2, >=2.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: synchronous active-low reset.
- start, in, 1: pulse, same cycle x/w are driven into the weighted sum.
- sum, in, 48: signed weighted sum from the DSP chain.
- bias, in, 48: signed Q30 bias; held static by the controller.
- mode, in, 1: 0 = step, 1 = ReLU; sampled together with sum.
- start_ok, out, 1: high when a new start can be accepted without loss.
- out_data, out, OUT_W: FIFO head.
- out_valid, out, 1: FIFO non-empty.
- out_ready, in, 1: consumer accepts head.
- overflow, out, 1: sticky; a result was saturated.
- dropped, out, 1: sticky; a result was discarded on a full FIFO.

Behaviour:
- Reset (rst_n=0 at an edge): clears the tracker, stage valids, FIFO pointers, count, overflow and dropped.
  - Outputs after reset: out_valid=0, out_data=0, start_ok=1.
  - In-flight results are lost. Reset mid-operation is legal from any state.
- Tracker: LATENCY-bit shift register. start enters bit 0; bit LATENCY-1 high is the tap.
- Stage 1 (edge where tap=1): acc = sext49(sum) + sext49(bias); mode is latched; v1 is set.
- Stage 2 (edge after v1):
  - s = acc >>> FRAC_SHIFT (floor).
  - Saturate s to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. If clipped, set overflow=1.
  - Step mode: result = 2^(OUT_W-1)-1 if acc>=0, else 0. Zero counts as positive. Saturation is not flagged in step mode.
  - ReLU mode: result = max(0, saturated s).
  - v2 is set.
- FIFO write (edge after v2): push result. out_valid rises the cycle after that edge.
  - Total: 3 edges from tap to out_valid when the FIFO is empty.
- Pop: an edge with out_valid and out_ready pops the head. out_data = head when non-empty, 0 when empty.
- Push on full FIFO:
  - With simultaneous pop: accepted; count unchanged.
  - Without pop: new result discarded, dropped=1, FIFO contents and order unchanged.
- start_ok = (count + popcount(tracker) + v1 + v2) < FIFO_DEPTH, registered.
  - A start issued while start_ok=0 is still tracked; overrun is the caller's fault and shows as dropped.
- Back-to-back starts every cycle are supported, one result per cycle.
- FIFO order equals start order.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- overflow and dropped clear only on reset.

Optional Feature:
- PERCEPTRON_ROUND_EN defined: stage 2 computes s = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, i.e. round half up. The add is done at 50 bits so it cannot wrap.
- Undefined: plain floor shift as above. Latency is identical either way.

Test Plan:
1. ReLU: sum=48'h0000_2000_0000, bias=0, single start -> out_data=16'h4000 on out_valid 3 cycles after the tap; overflow=0.
2. Step/ReLU on negatives: sum=-2^29. Step gives 16'h0000, ReLU gives 16'h0000. Then sum=0, step -> 16'h7FFF.
3. Saturation: sum=48'h0001_0000_0000, ReLU -> 16'h7FFF, overflow=1 and held until rst_n=0.
4. Bias and rounding: sum=0, bias=48'h0000_0000_8000 -> 16'h0001. Then sum=48'h0000_0000_4000, bias=0 -> 16'h0000 without PERCEPTRON_ROUND_EN, 16'h0001 with it.
5. Backpressure: FIFO_DEPTH=4, out_ready=0, starts on 6 consecutive cycles with sums 1..6 * 2^15.
   - start_ok falls after the 4th start.
   - Results 5 and 6 are dropped; dropped=1.
   - With out_ready=1, 1,2,3,4 are read in order, then out_valid=0 and out_data=0.
6. Reset mid-stream: 3 starts, rst_n=0 for one cycle 2 edges later -> no out_valid ever appears for those starts; start_ok=1; flags are 0.
